rx_link_deframer: RTL and testbench
===================================

# rx_link_deframer

Receive-side link layer that consumes decoded symbols from the CDR/8b10b receive path (RxParallel_8, RxDataK, Decode_Error, Disparity_Error) once per word clock. It runs a comma-based synchronization state machine to declare link up/down, strips idle and framing K-codes, and emits payload bytes with start/end-of-frame markers. It is the first stage downstream of the decoder.

## Interface
- COMMAS_TO_SYNC, 3: consecutive clean K28.5 symbols needed to acquire sync
- MAX_BAD, 4: bad-symbol count that drops sync
- GOOD_TO_RECOVER, 4: consecutive clean symbols that decrement the bad count
- ERR_CNT_W, 16: width of the error counter
- RxBitCLK_10  input  1  recovered word clock; one symbol per rising edge
- Reset  input  1  synchronous, active-high
- RxParallel_8  input  8  decoded symbol, type `data_symbol` from `enums`
- RxDataK  input  1  symbol is a K-code
- Decode_Error  input  1  invalid 10b code
- Disparity_Error  input  1  running-disparity violation
- err_clr  input  1  synchronous clear of err_count
- link_up  output  1  high in SYNC_ACQ and SYNC_ERR
- sync_state  output  2  current `sync_state_t`
- frame_data  output  8  payload byte
- frame_valid  output  1  frame_data valid this cycle
- frame_sop  output  1  first payload byte of a frame
- frame_eop  output  1  last payload byte of a frame
- frame_err  output  1  frame corrupt; valid only with frame_eop
- err_count  output  ERR_CNT_W  saturating count of bad symbols

## Operation
- Bad symbol: Decode_Error | Disparity_Error. Clean comma: RxDataK=1, data 8'hBC, not bad.
- Sync FSM states:
  - LOSS_OF_SYNC (2'd0): comma counter increments on each clean comma and clears on any bad symbol; other clean symbols hold it. Reaching COMMAS_TO_SYNC -> SYNC_ACQ, counter cleared.
  - SYNC_ACQ (2'd1): bad symbol -> SYNC_ERR with bad=1, good=0.
  - SYNC_ERR (2'd2): bad symbol -> bad+1, good=0; bad reaching MAX_BAD -> LOSS_OF_SYNC. Clean symbol -> good+1; at GOOD_TO_RECOVER, good=0 and bad-1; bad reaching 0 -> SYNC_ACQ.
- Framing is active only while link_up. K27.7 (8'hFB) = SOP, K29.7 (8'hFD) = EOP, K28.5 = idle.
- IDLE: SOP -> IN_FRAME, error flag cleared. Everything else is discarded.
- IN_FRAME: a clean data symbol enters a one-byte hold register. The previously held byte, if any, is emitted with frame_valid; frame_sop is set on the frame's first emitted byte.
- EOP in IN_FRAME: emit the held byte with frame_eop=1 and frame_err equal to the error flag, then go to IDLE. SOP followed immediately by EOP (empty frame) is dropped with no output.
- In-frame error flag is set by any bad symbol, or by any K-code other than SOP/EOP. That symbol is dropped and the frame stays open.
- SOP in IN_FRAME: emit the held byte with frame_eop=1 and frame_err=1, then start a new frame. If no byte is held, start the new frame silently.
- link_up falling in IN_FRAME: emit the held byte with eop=1 and err=1, then go to IDLE. If no byte is held, nothing is emitted.
- err_count increments on every bad symbol in any state and saturates at all-ones. If err_clr and a bad symbol occur together, the count becomes 0, not 1.

## Timing
- All outputs are registered. Reset values: sync_state=LOSS_OF_SYNC, link_up=0, frame_*=0, frame_data=0, err_count=0; hold register empty; frame FSM in IDLE.
- sync_state/link_up update the cycle after the deciding symbol is sampled.
- Payload latency: a byte sampled at edge N appears on frame_data at edge N+2 at the earliest. It waits until the next clean data symbol or the EOP arrives.
- frame_valid pulses one cycle per byte; there is no backpressure.
- Reset mid-frame discards the held byte and emits nothing.

## Structure
- In package `enums`: `sync_state_t` (LOSS_OF_SYNC, SYNC_ACQ, SYNC_ERR) and the constants K28_5=8'hBC, K27_7=8'hFB, K29_7=8'hFD.
- Sub-module `rx_sync_fsm` holds the comma, bad and good counters and outputs sync_state/link_up.
- `rx_link_deframer` holds the frame FSM, the hold register and err_count.

## Test plan
- After reset, 3 clean K28.5 symbols -> sync_state=SYNC_ACQ, link_up=1 one cycle after the third comma. The sequence K28.5, bad, K28.5, K28.5 -> sync still lost.
- In sync, send FB, 11, 22, 33, FD -> three frame_valid pulses: 11 with sop, 22, then 33 with eop and err=0. The first byte appears 2 cycles after it is sampled.
- In sync, send 4 bad symbols, each separated by fewer than 4 clean symbols -> SYNC_ERR after the first, LOSS_OF_SYNC after the fourth.
- In SYNC_ERR with bad=1, send 4 clean symbols -> SYNC_ACQ.
- Send FB, AA, bad, BB, FD -> AA sop, then BB eop with err=1. Send FB, FD -> no output.
- Send FB, 01, FB, 02, FD -> 01 with sop+eop+err=1, then 02 with sop+eop and err=0.
- With err_count at all-ones, a further bad symbol keeps it at all-ones. err_clr together with a bad symbol -> err_count=0.

Source files
------------

// File: rtl/enums.sv
// rtl/enums.sv - shared symbol type, sync/frame state enums and K-code constants
package enums;

    typedef logic [7:0] data_symbol;

    typedef enum logic [1:0] {
        LOSS_OF_SYNC = 2'd0,
        SYNC_ACQ     = 2'd1,
        SYNC_ERR     = 2'd2
    } sync_state_t;

    typedef enum logic {
        F_IDLE     = 1'b0,
        F_IN_FRAME = 1'b1
    } frame_state_t;

    localparam data_symbol K28_5 = 8'hBC;
    localparam data_symbol K27_7 = 8'hFB;
    localparam data_symbol K29_7 = 8'hFD;

endpackage

// File: rtl/rx_link_deframer_if.sv
// rtl/rx_link_deframer_if.sv - decoded-symbol input and framed-payload output bundle
interface rx_link_deframer_if #(
    parameter int ERR_CNT_W = 16
) ();
    import enums::*;

    data_symbol             RxParallel_8;
    logic                   RxDataK;
    logic                   Decode_Error;
    logic                   Disparity_Error;
    logic                   err_clr;
    logic                   link_up;
    sync_state_t            sync_state;
    data_symbol             frame_data;
    logic                   frame_valid;
    logic                   frame_sop;
    logic                   frame_eop;
    logic                   frame_err;
    logic [ERR_CNT_W-1:0]   err_count;

    modport master (
        output RxParallel_8, RxDataK, Decode_Error, Disparity_Error, err_clr,
        input  link_up, sync_state, frame_data, frame_valid, frame_sop,
               frame_eop, frame_err, err_count
    );

    modport slave (
        input  RxParallel_8, RxDataK, Decode_Error, Disparity_Error, err_clr,
        output link_up, sync_state, frame_data, frame_valid, frame_sop,
               frame_eop, frame_err, err_count
    );

endinterface

// File: rtl/rx_sync_fsm.sv
// rtl/rx_sync_fsm.sv - comma-based link synchronization state machine
module rx_sync_fsm
    import enums::*;
#(
    parameter int COMMAS_TO_SYNC  = 3,
    parameter int MAX_BAD         = 4,
    parameter int GOOD_TO_RECOVER = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sym_bad,
    input  logic        sym_comma,
    output sync_state_t sync_state,
    output logic        link_up
);
    localparam int CW = $clog2(COMMAS_TO_SYNC + 1);
    localparam int BW = $clog2(MAX_BAD + 1);
    localparam int GW = $clog2(GOOD_TO_RECOVER + 1);
    localparam logic [CW-1:0] COMMA_LAST = CW'(COMMAS_TO_SYNC - 1);
    localparam logic [BW-1:0] BAD_LAST   = BW'(MAX_BAD - 1);
    localparam logic [GW-1:0] GOOD_LAST  = GW'(GOOD_TO_RECOVER - 1);

    sync_state_t   state_q, state_d;
    logic [CW-1:0] comma_q, comma_d;
    logic [BW-1:0] bad_q, bad_d;
    logic [GW-1:0] good_q, good_d;
    logic          link_up_q, link_up_d;

    always_comb begin
        state_d = state_q;
        comma_d = comma_q;
        bad_d   = bad_q;
        good_d  = good_q;
        case (state_q)
            LOSS_OF_SYNC: begin
                if (sym_bad) begin
                    comma_d = '0;
                end else if (sym_comma) begin
                    if (comma_q == COMMA_LAST) begin
                        state_d = SYNC_ACQ;
                        comma_d = '0;
                    end else begin
                        comma_d = comma_q + CW'(1);
                    end
                end
            end
            SYNC_ACQ: begin
                if (sym_bad) begin
                    state_d = SYNC_ERR;
                    bad_d   = BW'(1);
                    good_d  = '0;
                end
            end
            SYNC_ERR: begin
                if (sym_bad) begin
                    good_d = '0;
                    if (bad_q == BAD_LAST) begin
                        state_d = LOSS_OF_SYNC;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_q + BW'(1);
                    end
                end else if (good_q == GOOD_LAST) begin
                    // a full run of clean symbols forgives one bad symbol
                    good_d = '0;
                    bad_d  = bad_q - BW'(1);
                    if (bad_q == BW'(1)) begin
                        state_d = SYNC_ACQ;
                    end
                end else begin
                    good_d = good_q + GW'(1);
                end
            end
            default: state_d = LOSS_OF_SYNC;
        endcase
        link_up_d = (state_d != LOSS_OF_SYNC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOSS_OF_SYNC;
            comma_q   <= '0;
            bad_q     <= '0;
            good_q    <= '0;
            link_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            comma_q   <= comma_d;
            bad_q     <= bad_d;
            good_q    <= good_d;
            link_up_q <= link_up_d;
        end
    end

    assign sync_state = state_q;
    assign link_up    = link_up_q;

endmodule

// File: rtl/rx_link_deframer.sv
// rtl/rx_link_deframer.sv - link sync, K-code stripping and payload framing after the 8b10b decoder
module rx_link_deframer
    import enums::*;
#(
    parameter int COMMAS_TO_SYNC  = 3,
    parameter int MAX_BAD         = 4,
    parameter int GOOD_TO_RECOVER = 4,
    parameter int ERR_CNT_W       = 16
) (
    input  logic               RxBitCLK_10,
    input  logic               Reset,
    rx_link_deframer_if.slave  lnk
);
    logic        raw_bad, raw_comma, link_up;
    sync_state_t sync_state;

    assign raw_bad   = lnk.Decode_Error | lnk.Disparity_Error;
    assign raw_comma = lnk.RxDataK && (lnk.RxParallel_8 == K28_5) && !raw_bad;

    rx_sync_fsm #(
        .COMMAS_TO_SYNC  (COMMAS_TO_SYNC),
        .MAX_BAD         (MAX_BAD),
        .GOOD_TO_RECOVER (GOOD_TO_RECOVER)
    ) u_sync (
        .clk        (RxBitCLK_10),
        .rst        (Reset),
        .sym_bad    (raw_bad),
        .sym_comma  (raw_comma),
        .sync_state (sync_state),
        .link_up    (link_up)
    );

    // framing runs one symbol behind so it sees link_up already updated by that symbol
    data_symbol           sym_q, sym_d, hold_q, hold_d, fdata_q, fdata_d;
    logic                 symk_q, symk_d, symbad_q, symbad_d;
    frame_state_t         fst_q, fst_d;
    logic                 held_q, held_d, first_q, first_d, ferr_q, ferr_d;
    logic                 fvalid_q, fvalid_d, fsop_q, fsop_d, feop_q, feop_d, fout_err_q, fout_err_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 emit, emit_eop, emit_err;

    always_comb begin
        sym_d    = lnk.RxParallel_8;
        symk_d   = lnk.RxDataK;
        symbad_d = raw_bad;

        err_d = err_q;
        if (lnk.err_clr) begin
            err_d = '0;
        end else if (raw_bad && (err_q != '1)) begin
            err_d = err_q + ERR_CNT_W'(1);
        end
    end

    always_comb begin
        fst_d      = fst_q;
        hold_d     = hold_q;
        held_d     = held_q;
        first_d    = first_q;
        ferr_d     = ferr_q;
        emit       = 1'b0;
        emit_eop   = 1'b0;
        emit_err   = 1'b0;
        if (!link_up) begin
            if (fst_q == F_IN_FRAME) begin
                emit     = held_q;
                emit_eop = 1'b1;
                emit_err = 1'b1;
            end
            fst_d  = F_IDLE;
            held_d = 1'b0;
        end else if (fst_q == F_IDLE) begin
            if (symk_q && (sym_q == K27_7) && !symbad_q) begin
                fst_d   = F_IN_FRAME;
                held_d  = 1'b0;
                ferr_d  = 1'b0;
                first_d = 1'b1;
            end
        end else if (symbad_q) begin
            ferr_d = 1'b1;
        end else if (symk_q && (sym_q == K29_7)) begin
            emit     = held_q;
            emit_eop = 1'b1;
            emit_err = ferr_q;
            fst_d    = F_IDLE;
            held_d   = 1'b0;
        end else if (symk_q && (sym_q == K27_7)) begin
            // SOP inside a frame truncates the open frame and starts a fresh one
            emit     = held_q;
            emit_eop = 1'b1;
            emit_err = 1'b1;
            held_d   = 1'b0;
            ferr_d   = 1'b0;
            first_d  = 1'b1;
        end else if (symk_q) begin
            ferr_d = 1'b1;
        end else begin
            emit   = held_q;
            hold_d = sym_q;
            held_d = 1'b1;
            if (held_q) begin
                first_d = 1'b0;
            end
        end

        fdata_d    = fdata_q;
        fvalid_d   = emit;
        fsop_d     = emit & first_q;
        feop_d     = emit & emit_eop;
        fout_err_d = emit & emit_err;
        if (emit) begin
            fdata_d = hold_q;
        end
    end

    always_ff @(posedge RxBitCLK_10) begin
        if (Reset) begin
            sym_q      <= '0;
            symk_q     <= 1'b0;
            symbad_q   <= 1'b0;
            err_q      <= '0;
            fst_q      <= F_IDLE;
            hold_q     <= '0;
            held_q     <= 1'b0;
            first_q    <= 1'b0;
            ferr_q     <= 1'b0;
            fdata_q    <= '0;
            fvalid_q   <= 1'b0;
            fsop_q     <= 1'b0;
            feop_q     <= 1'b0;
            fout_err_q <= 1'b0;
        end else begin
            sym_q      <= sym_d;
            symk_q     <= symk_d;
            symbad_q   <= symbad_d;
            err_q      <= err_d;
            fst_q      <= fst_d;
            hold_q     <= hold_d;
            held_q     <= held_d;
            first_q    <= first_d;
            ferr_q     <= ferr_d;
            fdata_q    <= fdata_d;
            fvalid_q   <= fvalid_d;
            fsop_q     <= fsop_d;
            feop_q     <= feop_d;
            fout_err_q <= fout_err_d;
        end
    end

    assign lnk.link_up     = link_up;
    assign lnk.sync_state  = sync_state;
    assign lnk.frame_data  = fdata_q;
    assign lnk.frame_valid = fvalid_q;
    assign lnk.frame_sop   = fsop_q;
    assign lnk.frame_eop   = feop_q;
    assign lnk.frame_err   = fout_err_q;
    assign lnk.err_count   = err_q;

endmodule

// File: tb/tb_rx_link_deframer.sv
// tb/tb_rx_link_deframer.sv - directed bench with symbol-level reference model for rx_link_deframer
module tb_rx_link_deframer;

    localparam int ERR_W   = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_link_deframer_if #(.ERR_CNT_W(ERR_W)) lnk ();

    rx_link_deframer #(.ERR_CNT_W(ERR_W)) dut (
        .RxBitCLK_10 (clk),
        .Reset       (rst),
        .lnk         (lnk)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit active = 0;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       err;
    } beat_t;
    beat_t log_q[$];

    // model state: sync status, error count, and the frame under construction
    int         m_state, m_commas, m_bad, m_good, m_errcnt;
    bit         fr_open, fr_held, fr_first, fr_err;
    logic [7:0] fr_byte;
    bit         exp_v, exp_sop, exp_eop, exp_err, nxt_v, nxt_sop, nxt_eop, nxt_err;
    logic [7:0] exp_d, nxt_d;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_commas = 0; m_bad = 0; m_good = 0; m_errcnt = 0;
        fr_open = 0; fr_held = 0; fr_first = 0; fr_err = 0; fr_byte = 0;
        exp_v = 0; exp_sop = 0; exp_eop = 0; exp_err = 0; exp_d = 0;
        nxt_v = 0; nxt_sop = 0; nxt_eop = 0; nxt_err = 0; nxt_d = 0;
    endtask

    task automatic model_emit(input bit eop, input bit err);
        nxt_v = 1; nxt_d = fr_byte; nxt_sop = fr_first; nxt_eop = eop; nxt_err = err;
    endtask

    task automatic model_open();
        fr_open = 1; fr_held = 0; fr_err = 0; fr_first = 1;
    endtask

    task automatic model_step(input logic [7:0] d, input logic k, input bit bad, input bit clr);
        bit comma;
        comma = k && d == 8'hBC && !bad;
        if (clr) m_errcnt = 0;
        else if (bad && m_errcnt < ERR_MAX) m_errcnt++;

        if (m_state == 0) begin
            if (bad) m_commas = 0;
            else if (comma) m_commas++;
            if (m_commas == 3) begin m_state = 1; m_commas = 0; end
        end else if (m_state == 1) begin
            if (bad) begin m_state = 2; m_bad = 1; m_good = 0; end
        end else if (bad) begin
            m_bad++; m_good = 0;
            if (m_bad == 4) m_state = 0;
        end else begin
            m_good++;
            if (m_good == 4) begin m_good = 0; m_bad--; end
            if (m_bad == 0) m_state = 1;
        end

        exp_v = nxt_v; exp_d = nxt_d; exp_sop = nxt_sop; exp_eop = nxt_eop; exp_err = nxt_err;
        nxt_v = 0; nxt_sop = 0; nxt_eop = 0; nxt_err = 0;
        if (m_state == 0) begin
            if (fr_open && fr_held) model_emit(1, 1);
            fr_open = 0; fr_held = 0;
        end else if (!fr_open) begin
            if (k && d == 8'hFB && !bad) model_open();
        end else if (bad) begin
            fr_err = 1;
        end else if (k && d == 8'hFD) begin
            if (fr_held) model_emit(1, fr_err);
            fr_open = 0; fr_held = 0;
        end else if (k && d == 8'hFB) begin
            if (fr_held) model_emit(1, 1);
            model_open();
        end else if (k) begin
            fr_err = 1;
        end else begin
            if (fr_held) begin model_emit(0, 0); fr_first = 0; end
            fr_byte = d; fr_held = 1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic k, input int bk, input logic clr);
        @(negedge clk);
        rst = 1'b0;
        lnk.RxParallel_8    = d;
        lnk.RxDataK         = k;
        lnk.Decode_Error    = (bk == 1);
        lnk.Disparity_Error = (bk == 2);
        lnk.err_clr         = clr;
        model_step(d, k, bk != 0, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();                      send(8'hBC, 1'b1, 0, 1'b0); endtask
    task automatic kc(input logic [7:0] d);     send(d, 1'b1, 0, 1'b0);     endtask
    task automatic dat(input logic [7:0] d);    send(d, 1'b0, 0, 1'b0);     endtask
    task automatic badsym(input int kind);      send(8'h5A, 1'b0, kind, 1'b0); endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        lnk.RxParallel_8 = '0; lnk.RxDataK = 0; lnk.Decode_Error = 0;
        lnk.Disparity_Error = 0; lnk.err_clr = 0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string name, input int idx, input logic [7:0] d,
                            input bit sop, input bit eop, input bit err);
        if (idx >= log_q.size()) begin
            chk({name, "_present"}, 0, 1);
        end else begin
            chk({name, "_data"}, log_q[idx].d, d);
            chk({name, "_sop"}, log_q[idx].sop, sop);
            chk({name, "_eop"}, log_q[idx].eop, eop);
            if (eop) chk({name, "_err"}, log_q[idx].err, err);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // per-cycle comparison against the model
    initial forever begin
        @(posedge clk);
        #1;
        if (active) begin
            chk("sync_state", int'(lnk.sync_state), m_state);
            chk("link_up", lnk.link_up, m_state != 0);
            chk("err_count", lnk.err_count, m_errcnt);
            chk("frame_valid", lnk.frame_valid, exp_v);
            if (exp_v && lnk.frame_valid) begin
                chk("frame_data", lnk.frame_data, exp_d);
                chk("frame_sop", lnk.frame_sop, exp_sop);
                chk("frame_eop", lnk.frame_eop, exp_eop);
                if (exp_eop) chk("frame_err", lnk.frame_err, exp_err);
            end
            if (lnk.frame_valid)
                log_q.push_back('{cyc, lnk.frame_data, lnk.frame_sop, lnk.frame_eop, lnk.frame_err});
        end
    end

    initial begin
        int c11;
        lnk.RxParallel_8 = '0; lnk.RxDataK = 0; lnk.Decode_Error = 0;
        lnk.Disparity_Error = 0; lnk.err_clr = 0;
        model_reset();
        do_reset();
        do_reset();
        active = 1;

        chk("rst_sync", int'(lnk.sync_state), 0);
        chk("rst_link", lnk.link_up, 0);
        chk("rst_valid", lnk.frame_valid, 0);
        chk("rst_data", lnk.frame_data, 0);
        chk("rst_errcnt", lnk.err_count, 0);

        idle(); badsym(1); idle(); idle();
        chk("lit_bad_breaks_commas", int'(lnk.sync_state), 0);

        do_reset();
        idle(); idle();
        chk("lit_two_commas_link", lnk.link_up, 0);
        idle();
        chk("lit_three_commas_sync", int'(lnk.sync_state), 1);
        chk("lit_three_commas_link", lnk.link_up, 1);

        log_q.delete();
        idle(); kc(8'hFB); dat(8'h11); c11 = cyc; dat(8'h22); dat(8'h33); kc(8'hFD); idle(); idle();
        chk("lit_basic_count", log_q.size(), 3);
        chk_beat("lit_basic0", 0, 8'h11, 1, 0, 0);
        chk_beat("lit_basic1", 1, 8'h22, 0, 0, 0);
        chk_beat("lit_basic2", 2, 8'h33, 0, 1, 0);
        if (log_q.size() > 0) chk("lit_first_latency", log_q[0].cyc - c11, 2);

        log_q.delete();
        kc(8'hFB); dat(8'hAA); badsym(1); dat(8'hBB); kc(8'hFD); idle();
        kc(8'hFB); kc(8'hFD); idle(); idle();
        chk("lit_err_count", log_q.size(), 2);
        chk_beat("lit_err0", 0, 8'hAA, 1, 0, 0);
        chk_beat("lit_err1", 1, 8'hBB, 0, 1, 1);

        log_q.delete();
        kc(8'hFB); dat(8'h01); kc(8'hFB); dat(8'h02); kc(8'hFD); idle(); idle();
        chk("lit_resop_count", log_q.size(), 2);
        chk_beat("lit_resop0", 0, 8'h01, 1, 1, 1);
        chk_beat("lit_resop1", 1, 8'h02, 1, 1, 0);

        log_q.delete();
        chk("lit_pre_loss_sync", int'(lnk.sync_state), 1);
        kc(8'hFB); dat(8'h55); badsym(2);
        chk("lit_first_bad_err", int'(lnk.sync_state), 2);
        dat(8'h66); dat(8'h77); badsym(1); dat(8'h88); badsym(2);
        dat(8'h99); dat(8'hAA);
        chk("lit_three_bad_still_err", int'(lnk.sync_state), 2);
        badsym(1);
        chk("lit_fourth_bad_loss", int'(lnk.sync_state), 0);
        idle(); idle();
        chk("lit_loss_count", log_q.size(), 6);
        chk_beat("lit_loss_first", 0, 8'h55, 1, 0, 0);
        chk_beat("lit_loss_last", 5, 8'hAA, 0, 1, 1);

        idle(); idle(); idle();
        chk("lit_resync", int'(lnk.sync_state), 1);
        badsym(1);
        chk("lit_recover_err", int'(lnk.sync_state), 2);
        dat(8'h10); dat(8'h20); idle();
        chk("lit_recover_three", int'(lnk.sync_state), 2);
        dat(8'h30);
        chk("lit_recover_four", int'(lnk.sync_state), 1);

        log_q.delete();
        kc(8'hFB); dat(8'h12); dat(8'h34);
        do_reset();
        idle(); idle(); idle(); dat(8'h56); idle(); idle();
        chk("lit_reset_midframe", log_q.size(), 0);

        send(8'hBC, 1'b1, 0, 1'b1);
        chk("lit_clr_only", lnk.err_count, 0);
        for (int i = 0; i < ERR_MAX + 2; i++) badsym(1 + (i % 2));
        chk("lit_saturate", lnk.err_count, ERR_MAX);
        send(8'h00, 1'b0, 1, 1'b1);
        chk("lit_clr_with_bad", lnk.err_count, 0);
        badsym(1);
        chk("lit_count_after_clr", lnk.err_count, 1);
        idle(); idle();

        active = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
